// File: rtl/spu_op_sequencer_if.sv
// Bundle of the command, operand, result-mux and result-FIFO signals of the SPU op sequencer.
// The slave modport is the sequencer itself; the master modport is the front-end plus shape units.
interface spu_op_sequencer_if #(
  parameter int N  = 32,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;
  logic [N-1:0]  cmd_m;
  logic [N-1:0]  cmd_p;
  logic [N-1:0]  cmd_d;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  op_m;
  logic [N-1:0]  op_p;
  logic [N-1:0]  op_d;
  logic [3:0]    op_sel;
  logic [N-1:0]  res_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [3:0]    out_op;
  logic          out_err;
  logic [CW-1:0] count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_m, cmd_p, cmd_d, res_in, out_ready,
    output cmd_ready, op_a, op_b, op_m, op_p, op_d, op_sel,
    output out_valid, out_data, out_op, out_err, count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_m, cmd_p, cmd_d, res_in, out_ready,
    input  cmd_ready, op_a, op_b, op_m, op_p, op_d, op_sel,
    input  out_valid, out_data, out_op, out_err, count
  );
endinterface

// File: rtl/spu_op_sequencer.sv
// Accepts one SPU op at a time, drives registered operands to the shape units, waits a fixed
// settle time, then captures the muxed unit result into a small FIFO drained by a consumer.
module spu_op_sequencer #(
  parameter int N          = 32,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  spu_op_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_settle;
  logic [N-1:0]   r_opA, r_opB, r_opM, r_opP, r_opD;
  logic [3:0]     r_opSel;

  logic [N-1:0]   r_memData [DEPTH];
  logic [3:0]     r_memOp   [DEPTH];
  logic           r_memErr  [DEPTH];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_cmdReady, w_accept, w_validOp, w_outValid;
  logic           w_push, w_pop;
  logic [N-1:0]   w_pushData;
  logic [3:0]     w_pushOp;
  logic           w_pushErr;

  assign w_cmdReady = (r_state == IDLE) && (r_count < CW'(DEPTH));
  assign w_accept   = bus.cmd_valid && w_cmdReady;
  assign w_validOp  = (bus.cmd_op <= 4'd10);
  assign w_outValid = (r_count != '0);
  assign w_pop      = w_outValid && bus.out_ready;

  // Invalid opcodes are answered on the accept edge; valid ones at the end of the settle window.
  always_comb begin
    w_push     = 1'b0;
    w_pushData = '0;
    w_pushOp   = '0;
    w_pushErr  = 1'b0;
    if (w_accept && !w_validOp) begin
      w_push    = 1'b1;
      w_pushOp  = bus.cmd_op;
      w_pushErr = 1'b1;
    end else if (r_state == SETTLE && r_settle == '0) begin
      w_push   = 1'b1;
      w_pushOp = r_opSel;
      if (r_opSel == 4'd1 && r_opB == '0) begin
        w_pushData = '1;
        w_pushErr  = 1'b1;
      end else begin
        w_pushData = bus.res_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_settle <= '0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_opM    <= '0;
      r_opP    <= '0;
      r_opD    <= '0;
      r_opSel  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opA    <= bus.cmd_a;
            r_opB    <= bus.cmd_b;
            r_opM    <= bus.cmd_m;
            r_opP    <= bus.cmd_p;
            r_opD    <= bus.cmd_d;
            r_opSel  <= bus.cmd_op;
            r_settle <= SW'(SETTLE_CYC - 1);
            if (w_validOp) r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_settle != '0) r_settle <= r_settle - SW'(1);
          else                r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memData[r_wptr] <= w_pushData;
      r_memOp[r_wptr]   <= w_pushOp;
      r_memErr[r_wptr]  <= w_pushErr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.cmd_ready = w_cmdReady;
  assign bus.op_a      = r_opA;
  assign bus.op_b      = r_opB;
  assign bus.op_m      = r_opM;
  assign bus.op_p      = r_opP;
  assign bus.op_d      = r_opD;
  assign bus.op_sel    = r_opSel;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = w_outValid ? r_memData[r_rptr] : '0;
  assign bus.out_op    = w_outValid ? r_memOp[r_rptr]   : '0;
  assign bus.out_err   = w_outValid ? r_memErr[r_rptr]  : 1'b0;
  assign bus.count     = r_count;
endmodule
